// File: rtl/ifetch_queue.sv
// Instruction fetch front end: owns the fetch PC, issues one-word reads, buffers the returned words
// and hands them to the decoder. Optional JAL next-PC prediction is enabled with IF_JAL_PREDICT_EN.
module ifetch_queue #(
  parameter int unsigned QUEUE_DEPTH_LOG = 2,
  parameter logic [31:0] RESET_PC        = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        dec_stall,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        pred_taken
);

  localparam int unsigned DEPTH = 1 << QUEUE_DEPTH_LOG;
  localparam logic [QUEUE_DEPTH_LOG-1:0] PTR_ONE   = QUEUE_DEPTH_LOG'(1);
  localparam logic [QUEUE_DEPTH_LOG:0]   CNT_ONE   = (QUEUE_DEPTH_LOG + 1)'(1);
  localparam logic [QUEUE_DEPTH_LOG:0]   DEPTH_CNT = (QUEUE_DEPTH_LOG + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, FLUSH} state_e;

  state_e                     state_q, state_d;
  logic [31:0]                fetch_pc_q, fetch_pc_d;
  logic                       mem_req_q, mem_req_d;
  logic [31:0]                mem_addr_q, mem_addr_d;
  logic [QUEUE_DEPTH_LOG-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [QUEUE_DEPTH_LOG:0]   count_q, count_d, cnt_after_pop;
  logic [31:0]                q_word_q [DEPTH];
  logic [31:0]                q_word_d [DEPTH];
  logic [31:0]                q_pc_q   [DEPTH];
  logic [31:0]                q_pc_d   [DEPTH];
  logic                       q_pred_q [DEPTH];
  logic                       q_pred_d [DEPTH];
  logic                       instr_valid_q, instr_valid_d;
  logic [31:0]                instr_q, instr_d;
  logic [31:0]                instr_pc_q, instr_pc_d;
  logic                       pred_q, pred_d;
  logic                       pop, push;
  logic [31:0]                next_pc;
  logic                       push_pred;

`ifdef IF_JAL_PREDICT_EN
  logic        is_jal;
  logic [31:0] jal_imm;
  assign is_jal    = (mem_data[6:0] == 7'b1101111);
  assign jal_imm   = {{11{mem_data[31]}}, mem_data[31], mem_data[19:12], mem_data[20],
                      mem_data[30:21], 1'b0};
  assign next_pc   = is_jal ? (mem_addr_q + jal_imm) : (mem_addr_q + 32'd4);
  assign push_pred = is_jal;
`else
  assign next_pc   = mem_addr_q + 32'd4;
  assign push_pred = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    mem_req_d     = mem_req_q;
    mem_addr_d    = mem_addr_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    q_word_d      = q_word_q;
    q_pc_d        = q_pc_q;
    q_pred_d      = q_pred_q;
    instr_valid_d = instr_valid_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    pred_d        = pred_q;

    pop           = !redirect_valid && (count_q != '0) && (!instr_valid_q || !dec_stall);
    push          = !redirect_valid && (state_q == WAIT) && mem_ack;
    cnt_after_pop = count_q - (pop ? CNT_ONE : '0);

    if (redirect_valid) begin
      instr_valid_d = 1'b0;
    end else if (pop) begin
      instr_valid_d = 1'b1;
      instr_d       = q_word_q[rd_ptr_q];
      instr_pc_d    = q_pc_q[rd_ptr_q];
      pred_d        = q_pred_q[rd_ptr_q];
    end else if (instr_valid_q && !dec_stall) begin
      instr_valid_d = 1'b0;
    end

    if (redirect_valid) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (push) begin
        q_word_d[wr_ptr_q] = mem_data;
        q_pc_d[wr_ptr_q]   = mem_addr_q;
        q_pred_d[wr_ptr_q] = push_pred;
        wr_ptr_d           = wr_ptr_q + PTR_ONE;
      end
      count_d = cnt_after_pop + (push ? CNT_ONE : '0);
    end

    // A redirect always retargets fetch; the in-flight read (if not acked now) drains through FLUSH.
    if (redirect_valid) fetch_pc_d = {redirect_pc[31:2], 2'b00};

    case (state_q)
      IDLE: begin
        if (!redirect_valid && (cnt_after_pop < DEPTH_CNT)) begin
          mem_req_d  = 1'b1;
          mem_addr_d = fetch_pc_q;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = IDLE;
          if (!redirect_valid) fetch_pc_d = next_pc;
        end else if (redirect_valid) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      fetch_pc_q    <= RESET_PC;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      instr_valid_q <= 1'b0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      pred_q        <= 1'b0;
    end else if (rdy) begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      q_word_q      <= q_word_d;
      q_pc_q        <= q_pc_d;
      q_pred_q      <= q_pred_d;
      instr_valid_q <= instr_valid_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      pred_q        <= pred_d;
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign pred_taken  = pred_q;

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: a cycle table from reset, directed stall/JAL sequences, and a randomized
// run scored against a program-order model of the fetch stream.
module tb_ifetch_queue;

  logic        clk = 1'b0;
  logic        rst, rdy, mem_ack, redirect_valid, dec_stall;
  logic [31:0] mem_data, redirect_pc;
  logic        mem_req, instr_valid, pred_taken;
  logic [31:0] mem_addr, instr, instr_pc;

  always #5 clk = ~clk;

  ifetch_queue #(.QUEUE_DEPTH_LOG(2), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .dec_stall(dec_stall),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .pred_taken(pred_taken)
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned n_xfer = 0;
  logic [31:0] exp_pc = 32'h0;
  logic [31:0] xfer_log[$];
  logic        xpred_log[$];
  logic [31:0] ack_log[$];
  bit          auto_mem = 1'b0;
  int unsigned lat = 1, lat_cnt = 0;

  // Program image: a hashed word per address, with a JAL (jal x0,+8) planted at 0x10.
  function automatic logic [31:0] memword(input logic [31:0] a);
    if (a == 32'h10) return 32'h0080006F;
    return ((a * 32'h9E3779B1) ^ 32'h5A5A1234) & 32'hFFFF_FFFC;
  endfunction

  function automatic logic exp_pred(input logic [31:0] w);
`ifdef IF_JAL_PREDICT_EN
    return w[6:0] == 7'h6F;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] exp_next(input logic [31:0] pc, input logic [31:0] w);
    logic [20:0] j;
    j = {w[31], w[19:12], w[20], w[30:21], 1'b0};
    if (exp_pred(w)) return pc + {{11{j[20]}}, j};
    return pc + 32'd4;
  endfunction

  task automatic chk(input string name, input logic [98:0] act, input logic [98:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // One clock: note what happens at the edge, advance, then score and drive the memory responder.
  task automatic cycle();
    logic        xfer, acc, hold, xpred;
    logic [31:0] xpc, xin, raddr;
    logic [98:0] snap;
    xfer  = !rst && rdy && !redirect_valid && instr_valid && !dec_stall;
    xpc   = instr_pc;
    xin   = instr;
    xpred = pred_taken;
    acc   = !rst && rdy && mem_ack;
    hold  = !rst && !rdy;
    raddr = mem_addr;
    snap  = {mem_req, mem_addr, instr_valid, instr, instr_pc, pred_taken};
    @(posedge clk);
    @(negedge clk);
    if (hold) chk("freeze", {mem_req, mem_addr, instr_valid, instr, instr_pc, pred_taken}, snap);
    if (xfer) begin
      chk("xfer_pc", 99'(xpc), 99'(exp_pc));
      chk("xfer_word", 99'(xin), 99'(memword(exp_pc)));
      chk("xfer_pred", 99'(xpred), 99'(exp_pred(memword(exp_pc))));
      xfer_log.push_back(xpc);
      xpred_log.push_back(xpred);
      n_xfer++;
      exp_pc = exp_next(exp_pc, memword(exp_pc));
    end
    if (!rst && rdy && redirect_valid) exp_pc = {redirect_pc[31:2], 2'b00};
    if (acc) ack_log.push_back(raddr);
    if (auto_mem) begin
      if (acc) begin
        mem_ack = 1'b0;
        lat_cnt = 0;
      end else if (mem_req && !mem_ack) begin
        lat_cnt++;
        if (lat_cnt >= lat) begin
          mem_ack  = 1'b1;
          mem_data = memword(mem_addr);
        end
      end
    end
  endtask

  typedef struct {
    bit          rdy, redir, ack;
    logic [31:0] rpc;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_valid;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vt[19];

  initial begin
    #400000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int unsigned base, ai, xi;
    logic [31:0] held_instr, held_pc;
    bit found;

    vt[0]  = '{1, 0, 0, 32'h0,   1, 32'h0,   0, 32'h0};
    vt[1]  = '{1, 0, 1, 32'h0,   0, 32'h0,   0, 32'h0};
    vt[2]  = '{1, 0, 0, 32'h0,   1, 32'h4,   1, 32'h0};
    vt[3]  = '{1, 0, 1, 32'h0,   0, 32'h0,   0, 32'h0};
    vt[4]  = '{1, 0, 0, 32'h0,   1, 32'h8,   1, 32'h4};
    vt[5]  = '{1, 0, 1, 32'h0,   0, 32'h0,   0, 32'h0};
    vt[6]  = '{1, 0, 0, 32'h0,   1, 32'hC,   1, 32'h8};
    vt[7]  = '{1, 1, 0, 32'h103, 1, 32'hC,   0, 32'h0};
    vt[8]  = '{1, 0, 0, 32'h0,   1, 32'hC,   0, 32'h0};
    vt[9]  = '{1, 0, 1, 32'h0,   0, 32'h0,   0, 32'h0};
    vt[10] = '{1, 0, 0, 32'h0,   1, 32'h100, 0, 32'h0};
    vt[11] = '{1, 0, 1, 32'h0,   0, 32'h0,   0, 32'h0};
    vt[12] = '{1, 0, 0, 32'h0,   1, 32'h104, 1, 32'h100};
    vt[13] = '{1, 1, 1, 32'h200, 0, 32'h0,   0, 32'h0};
    vt[14] = '{1, 0, 0, 32'h0,   1, 32'h200, 0, 32'h0};
    vt[15] = '{0, 0, 0, 32'h0,   1, 32'h200, 0, 32'h0};
    vt[16] = '{0, 0, 0, 32'h0,   1, 32'h200, 0, 32'h0};
    vt[17] = '{1, 0, 1, 32'h0,   0, 32'h0,   0, 32'h0};
    vt[18] = '{1, 0, 0, 32'h0,   1, 32'h204, 1, 32'h200};

    rst = 1'b1; rdy = 1'b1; mem_ack = 1'b0; mem_data = '0; dec_stall = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h400;
    @(negedge clk);
    cycle();
    cycle();
    chk("rst_req", 99'(mem_req), 99'(0));
    chk("rst_addr", 99'(mem_addr), 99'(0));
    chk("rst_valid", 99'(instr_valid), 99'(0));
    chk("rst_out", {instr, instr_pc, pred_taken}, '0);
    rst = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;

    for (int i = 0; i < 19; i++) begin
      rdy            = vt[i].rdy;
      redirect_valid = vt[i].redir;
      redirect_pc    = vt[i].rpc;
      mem_ack        = vt[i].ack;
      mem_data       = memword(mem_addr);
      cycle();
      chk($sformatf("tbl%0d_req", i), 99'(mem_req), 99'(vt[i].e_req));
      if (vt[i].e_req) chk($sformatf("tbl%0d_addr", i), 99'(mem_addr), 99'(vt[i].e_addr));
      chk($sformatf("tbl%0d_valid", i), 99'(instr_valid), 99'(vt[i].e_valid));
      if (vt[i].e_valid) begin
        chk($sformatf("tbl%0d_pc", i), 99'(instr_pc), 99'(vt[i].e_pc));
        chk($sformatf("tbl%0d_instr", i), 99'(instr), 99'(memword(vt[i].e_pc)));
        chk($sformatf("tbl%0d_pred", i), 99'(pred_taken), 99'(0));
      end
    end
    rdy = 1'b1; redirect_valid = 1'b0; mem_ack = 1'b0;

    // Decoder stall: queue fills, fetch stops, then five back-to-back deliveries on release.
    auto_mem = 1'b1; lat = 1; lat_cnt = 0;
    repeat (8) cycle();
    dec_stall = 1'b1;
    cycle(); cycle();
    held_instr = instr; held_pc = instr_pc;
    repeat (18) cycle();
    chk("stall_req_idle", 99'(mem_req), 99'(0));
    chk("stall_valid", 99'(instr_valid), 99'(1));
    chk("stall_instr_held", 99'(instr), 99'(held_instr));
    chk("stall_pc_held", 99'(instr_pc), 99'(held_pc));
    dec_stall = 1'b0;
    base = n_xfer;
    repeat (5) cycle();
    chk("release_burst", 99'(n_xfer - base), 99'(5));

    // Redirect onto the JAL at 0x10 and look at what follows it.
    redirect_valid = 1'b1; redirect_pc = 32'h10;
    ai = ack_log.size(); xi = xfer_log.size();
    cycle();
    redirect_valid = 1'b0;
    repeat (40) cycle();
    found = 1'b0;
    for (int k = int'(ai) + 1; k + 1 < ack_log.size(); k++) begin
      if (!found && ack_log[k] == 32'h10) begin
        found = 1'b1;
`ifdef IF_JAL_PREDICT_EN
        chk("jal_next_addr", 99'(ack_log[k+1]), 99'(32'h18));
`else
        chk("jal_next_addr", 99'(ack_log[k+1]), 99'(32'h14));
`endif
      end
    end
    chk("jal_fetched", 99'(found), 99'(1));
    chk("jal_first_pc", 99'((xfer_log.size() > xi) ? xfer_log[xi] : 32'hFFFF_FFFF), 99'(32'h10));
    if (xfer_log.size() > xi + 1) begin
`ifdef IF_JAL_PREDICT_EN
      chk("jal_pred", 99'(xpred_log[xi]), 99'(1));
      chk("jal_second_pc", 99'(xfer_log[xi+1]), 99'(32'h18));
`else
      chk("jal_pred", 99'(xpred_log[xi]), 99'(0));
      chk("jal_second_pc", 99'(xfer_log[xi+1]), 99'(32'h14));
`endif
    end else begin
      chk("jal_second_seen", 99'(0), 99'(1));
    end

    // Randomized traffic against the program-order model.
    base = n_xfer;
    for (int c = 0; c < 3000; c++) begin
      rdy            = ($urandom_range(0, 9) != 0);
      dec_stall      = ($urandom_range(0, 9) < 3);
      redirect_valid = ($urandom_range(0, 99) < 3);
      redirect_pc    = $urandom_range(0, 255);
      if (lat_cnt == 0) lat = $urandom_range(1, 4);
      cycle();
    end
    redirect_valid = 1'b0;
    chk("rand_progress", 99'(n_xfer - base > 200), 99'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
